// File: rtl/regfile_pkg.sv
// Shared types and default constants for the regfile_display register file and its
// LED scan controller.
package regfile_pkg;

  typedef enum logic {
    DISP_MANUAL = 1'b0,
    DISP_AUTO   = 1'b1
  } disp_state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_SCAN_DIV = 4;
  localparam int LANE_W       = 8;

endpackage

// File: rtl/regfile_scan_ctrl.sv
// Display byte-index sequencer: manual byte select or timed auto scan across the
// byte lanes. It owns the mode FSM, the scan divider and the Disp_Idx register.
module regfile_scan_ctrl
  import regfile_pkg::*;
#(
  parameter int NBYTES   = 4,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int IDX_W    = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Disp_Auto,
  input  logic [IDX_W-1:0] Disp_Byte,
  output logic [IDX_W-1:0] Disp_Idx,
  output logic [IDX_W-1:0] idx_next
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

  disp_state_t      state, state_next;
  logic [DIV_W-1:0] div, div_next;
  logic [IDX_W-1:0] byte_clamped;

  always_comb begin
    byte_clamped = (int'(Disp_Byte) >= NBYTES) ? LAST_IDX : Disp_Byte;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= DISP_MANUAL;
      div      <= '0;
      Disp_Idx <= '0;
    end else begin
      state    <= state_next;
      div      <= div_next;
      Disp_Idx <= idx_next;
    end
  end

  // Entering auto holds the current index; the first step comes SCAN_DIV edges later.
  always_comb begin
    state_next = state;
    div_next   = '0;
    idx_next   = Disp_Idx;
    case (state)
      DISP_MANUAL: begin
        if (Disp_Auto) state_next = DISP_AUTO;
        else           idx_next   = byte_clamped;
      end
      DISP_AUTO: begin
        if (!Disp_Auto) begin
          state_next = DISP_MANUAL;
          idx_next   = byte_clamped;
        end else if (div == LAST_DIV) begin
          idx_next = (Disp_Idx == LAST_IDX) ? '0 : Disp_Idx + 1'b1;
        end else begin
          div_next = div + 1'b1;
        end
      end
      default: state_next = DISP_MANUAL;
    endcase
  end

endmodule

// File: rtl/regfile_display.sv
// 2-read/1-write register file with byte-lane writes and a registered LED byte display.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_display
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int SCAN_DIV = DEF_SCAN_DIV,
  localparam int NBYTES   = DATA_W / LANE_W,
  localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              W_En,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic [NBYTES-1:0] W_BE,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  input  logic              Disp_Sel,
  input  logic              Disp_Auto,
  input  logic [IDX_W-1:0]  Disp_Byte,
  output logic [7:0]        LED,
  output logic [IDX_W-1:0]  Disp_Idx
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] src;
  logic [IDX_W-1:0]  idx_next;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (W_En && W_Addr != '0) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (W_BE[b]) mem[W_Addr][LANE_W*b +: LANE_W] <= W_Data[LANE_W*b +: LANE_W];
      end
    end
  end

  always_comb begin
    R_Data_A = (R_Addr_A == '0) ? '0 : mem[R_Addr_A];
`ifdef REGFILE_BYPASS_EN
    if (W_En && W_Addr == R_Addr_A && W_Addr != '0) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (W_BE[b]) R_Data_A[LANE_W*b +: LANE_W] = W_Data[LANE_W*b +: LANE_W];
      end
    end
`endif
  end

  always_comb begin
    R_Data_B = (R_Addr_B == '0) ? '0 : mem[R_Addr_B];
`ifdef REGFILE_BYPASS_EN
    if (W_En && W_Addr == R_Addr_B && W_Addr != '0) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (W_BE[b]) R_Data_B[LANE_W*b +: LANE_W] = W_Data[LANE_W*b +: LANE_W];
      end
    end
`endif
  end

  always_comb begin
    src = Disp_Sel ? R_Data_A : R_Data_B;
  end

  regfile_scan_ctrl #(
    .NBYTES   (NBYTES),
    .SCAN_DIV (SCAN_DIV),
    .IDX_W    (IDX_W)
  ) u_scan_ctrl (
    .Clk       (Clk),
    .Reset     (Reset),
    .Disp_Auto (Disp_Auto),
    .Disp_Byte (Disp_Byte),
    .Disp_Idx  (Disp_Idx),
    .idx_next  (idx_next)
  );

  // LED samples the byte the index register is about to hold, keeping the pair aligned.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) LED <= '0;
    else        LED <= src[LANE_W*int'(idx_next) +: LANE_W];
  end

endmodule

// File: tb/tb_regfile_display.sv
// Self-checking bench for regfile_display: directed scenarios plus randomized traffic
// compared against a behavioural register-file and display model.
module tb_regfile_display;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int SCAN_DIV = 4;
  localparam int NBYTES   = 4;
  localparam int IDX_W    = 2;
  localparam int DEPTH    = 32;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              W_En;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;
  logic [NBYTES-1:0] W_BE;
  logic [ADDR_W-1:0] R_Addr_A, R_Addr_B;
  logic [DATA_W-1:0] R_Data_A, R_Data_B;
  logic              Disp_Sel, Disp_Auto;
  logic [IDX_W-1:0]  Disp_Byte;
  logic [7:0]        LED;
  logic [IDX_W-1:0]  Disp_Idx;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mm [DEPTH];
  bit                m_auto;
  int                m_count;
  int                m_idx;
  logic [7:0]        m_led;

  regfile_display #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .W_En      (W_En),
    .W_Addr    (W_Addr),
    .W_Data    (W_Data),
    .W_BE      (W_BE),
    .R_Addr_A  (R_Addr_A),
    .R_Addr_B  (R_Addr_B),
    .R_Data_A  (R_Data_A),
    .R_Data_B  (R_Data_B),
    .Disp_Sel  (Disp_Sel),
    .Disp_Auto (Disp_Auto),
    .Disp_Byte (Disp_Byte),
    .LED       (LED),
    .Disp_Idx  (Disp_Idx)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = (addr == 0) ? '0 : mm[addr];
`ifdef REGFILE_BYPASS_EN
    if (W_En && W_Addr == addr && addr != 0)
      for (int b = 0; b < NBYTES; b++)
        if (W_BE[b]) v[8*b +: 8] = W_Data[8*b +: 8];
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    m_auto  = 1'b0;
    m_count = 0;
    m_idx   = 0;
    m_led   = '0;
  endtask

  // Advance one clock edge, updating the model from the inputs seen before the edge.
  task automatic cycle();
    logic [DATA_W-1:0] src;
    int sel_byte;
    src      = Disp_Sel ? exp_read(R_Addr_A) : exp_read(R_Addr_B);
    sel_byte = (int'(Disp_Byte) >= NBYTES) ? NBYTES - 1 : int'(Disp_Byte);
    if (!m_auto) begin
      if (Disp_Auto) begin
        m_auto  = 1'b1;
        m_count = 0;
      end else begin
        m_idx = sel_byte;
      end
    end else if (!Disp_Auto) begin
      m_auto = 1'b0;
      m_idx  = sel_byte;
    end else begin
      m_count++;
      if (m_count == SCAN_DIV) begin
        m_count = 0;
        m_idx   = (m_idx + 1) % NBYTES;
      end
    end
    m_led = src[8*m_idx +: 8];
    if (W_En && W_Addr != 0)
      for (int b = 0; b < NBYTES; b++)
        if (W_BE[b]) mm[W_Addr][8*b +: 8] = W_Data[8*b +: 8];
    @(posedge Clk);
    #1;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [NBYTES-1:0] be);
    W_En   = 1'b1;
    W_Addr = addr;
    W_Data = data;
    W_BE   = be;
    cycle();
    W_En = 1'b0;
    W_BE = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    W_En = 0; W_Addr = 0; W_Data = 0; W_BE = 0;
    R_Addr_A = 5'd3; R_Addr_B = 5'd0;
    Disp_Sel = 0; Disp_Auto = 0; Disp_Byte = 0;
    model_reset();
    #2;
    checks++; if (LED !== 8'h00) begin errors++; $display("[TB] FAIL reset_led: got %h expected 00", LED); end
    checks++; if (Disp_Idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d expected 0", Disp_Idx); end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    checks++; if (R_Data_A !== 32'h0) begin errors++; $display("[TB] FAIL reset_read3: got %h expected 00000000", R_Data_A); end
  endtask

  task automatic test_write_lanes();
    write_reg(5'd5, 32'h000F000F, 4'hF);
    write_reg(5'd5, 32'hFFFFFFFF, 4'b0010);
    R_Addr_A = 5'd5;
    #1;
    checks++; if (R_Data_A !== 32'h000FFF0F) begin errors++; $display("[TB] FAIL lane_merge: got %h expected 000FFF0F", R_Data_A); end
    write_reg(5'd0, 32'hFFFFFFFF, 4'hF);
    R_Addr_B = 5'd0;
    #1;
    checks++; if (R_Data_B !== 32'h0) begin errors++; $display("[TB] FAIL reg0_zero: got %h expected 00000000", R_Data_B); end
    write_reg(5'd5, 32'h12345678, 4'h0);
    #1;
    checks++; if (R_Data_A !== 32'h000FFF0F) begin errors++; $display("[TB] FAIL be_zero_noop: got %h expected 000FFF0F", R_Data_A); end
  endtask

  task automatic test_manual_display();
    write_reg(5'd5, 32'hF0F0F0F0, 4'hF);
    R_Addr_A = 5'd5; Disp_Sel = 1; Disp_Auto = 0; Disp_Byte = 2'd2;
    cycle();
    checks++; if (LED !== 8'hF0) begin errors++; $display("[TB] FAIL manual_led_a: got %h expected F0", LED); end
    checks++; if (Disp_Idx !== 2'd2) begin errors++; $display("[TB] FAIL manual_idx: got %0d expected 2", Disp_Idx); end
    Disp_Sel = 0; R_Addr_B = 5'd0;
    cycle();
    checks++; if (LED !== 8'h00) begin errors++; $display("[TB] FAIL manual_led_b0: got %h expected 00", LED); end
    R_Addr_B = 5'd5; Disp_Byte = 2'd1;
    cycle();
    checks++; if (LED !== m_led) begin errors++; $display("[TB] FAIL manual_led_b5: got %h expected %h", LED, m_led); end
  endtask

  task automatic test_auto_scan();
    write_reg(5'd6, 32'h0F0F0F00, 4'hF);
    R_Addr_A = 5'd6; Disp_Sel = 1; Disp_Byte = 2'd0; Disp_Auto = 0;
    cycle();
    Disp_Auto = 1;
    for (int k = 0; k < 17; k++) begin
      cycle();
      checks++; if (Disp_Idx !== IDX_W'(m_idx)) begin errors++; $display("[TB] FAIL auto_idx[%0d]: got %0d expected %0d", k, Disp_Idx, m_idx); end
      checks++; if (LED !== m_led) begin errors++; $display("[TB] FAIL auto_led[%0d]: got %h expected %h", k, LED, m_led); end
    end
    Disp_Auto = 0; Disp_Byte = 2'd1;
    cycle();
    checks++; if (Disp_Idx !== 2'd1) begin errors++; $display("[TB] FAIL auto_exit_idx: got %0d expected 1", Disp_Idx); end
    checks++; if (LED !== 8'h0F) begin errors++; $display("[TB] FAIL auto_exit_led: got %h expected 0F", LED); end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] expect_now;
    write_reg(5'd7, 32'h11223344, 4'hF);
    R_Addr_A = 5'd7;
    W_En = 1; W_Addr = 5'd7; W_Data = 32'hFFFFFFFF; W_BE = 4'hF;
`ifdef REGFILE_BYPASS_EN
    expect_now = 32'hFFFFFFFF;
`else
    expect_now = 32'h11223344;
`endif
    #1;
    checks++; if (R_Data_A !== expect_now) begin errors++; $display("[TB] FAIL rdw_same_cycle: got %h expected %h", R_Data_A, expect_now); end
    cycle();
    W_En = 0; W_BE = 0;
    #1;
    checks++; if (R_Data_A !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL rdw_next_cycle: got %h expected FFFFFFFF", R_Data_A); end
    W_En = 1; W_Addr = 5'd7; W_Data = 32'h0; W_BE = 4'b0101; R_Addr_B = 5'd7;
    #1;
    checks++; if (R_Data_B !== exp_read(5'd7)) begin errors++; $display("[TB] FAIL rdw_partial: got %h expected %h", R_Data_B, exp_read(5'd7)); end
    cycle();
    W_En = 0; W_BE = 0;
    #1;
    checks++; if (R_Data_B !== 32'hFF00FF00) begin errors++; $display("[TB] FAIL partial_after: got %h expected FF00FF00", R_Data_B); end
  endtask

  task automatic test_write_during_scan();
    R_Addr_A = 5'd6; Disp_Sel = 1; Disp_Auto = 1;
    for (int k = 0; k < 14; k++) begin
      if (k == 3 || k == 6 || k == 10) begin
        W_En = 1; W_Addr = 5'd6; W_Data = $urandom(); W_BE = (k == 6) ? 4'b1010 : 4'hF;
      end else begin
        W_En = 0; W_BE = 0;
      end
      cycle();
      checks++; if (LED !== m_led) begin errors++; $display("[TB] FAIL scan_write_led[%0d]: got %h expected %h", k, LED, m_led); end
    end
    W_En = 0; W_BE = 0; Disp_Auto = 0;
    cycle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      W_En     = $urandom_range(0, 1);
      W_Addr   = ADDR_W'($urandom_range(0, 7));
      W_Data   = $urandom();
      W_BE     = NBYTES'($urandom_range(0, 15));
      R_Addr_A = ADDR_W'($urandom_range(0, 7));
      R_Addr_B = ADDR_W'($urandom_range(0, 7));
      Disp_Sel = $urandom_range(0, 1);
      Disp_Byte = IDX_W'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) Disp_Auto = ~Disp_Auto;
      #1;
      checks++; if (R_Data_A !== exp_read(R_Addr_A)) begin errors++; $display("[TB] FAIL rand_rd_a[%0d]: got %h expected %h", k, R_Data_A, exp_read(R_Addr_A)); end
      checks++; if (R_Data_B !== exp_read(R_Addr_B)) begin errors++; $display("[TB] FAIL rand_rd_b[%0d]: got %h expected %h", k, R_Data_B, exp_read(R_Addr_B)); end
      cycle();
      checks++; if (LED !== m_led) begin errors++; $display("[TB] FAIL rand_led[%0d]: got %h expected %h", k, LED, m_led); end
      checks++; if (Disp_Idx !== IDX_W'(m_idx)) begin errors++; $display("[TB] FAIL rand_idx[%0d]: got %0d expected %0d", k, Disp_Idx, m_idx); end
    end
    W_En = 0; W_BE = 0;
  endtask

  task automatic test_reset_mid();
    write_reg(5'd5, 32'hA5A5A5A5, 4'hF);
    R_Addr_A = 5'd5; R_Addr_B = 5'd7; Disp_Sel = 1; Disp_Auto = 1;
    for (int k = 0; k < 6; k++) cycle();
    #3;
    Reset = 1'b0;
    model_reset();
    #1;
    checks++; if (LED !== 8'h00) begin errors++; $display("[TB] FAIL midreset_led: got %h expected 00", LED); end
    checks++; if (Disp_Idx !== 2'd0) begin errors++; $display("[TB] FAIL midreset_idx: got %0d expected 0", Disp_Idx); end
    checks++; if (R_Data_A !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rd_a: got %h expected 00000000", R_Data_A); end
    checks++; if (R_Data_B !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rd_b: got %h expected 00000000", R_Data_B); end
    @(posedge Clk);
    #1;
    checks++; if (LED !== 8'h00) begin errors++; $display("[TB] FAIL reset_hold_led: got %h expected 00", LED); end
    Reset = 1'b1;
    cycle();
    checks++; if (Disp_Idx !== 2'd0) begin errors++; $display("[TB] FAIL release_idx: got %0d expected 0", Disp_Idx); end
    R_Addr_A = 5'd3;
    #1;
    checks++; if (R_Data_A !== 32'h0) begin errors++; $display("[TB] FAIL release_read3: got %h expected 00000000", R_Data_A); end
    Disp_Auto = 0;
  endtask

  initial begin
    test_reset();
    test_write_lanes();
    test_manual_display();
    test_auto_scan();
    test_bypass();
    test_write_during_scan();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
